// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// default frame header and the bit-counter sizing helper.
package seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PRE  = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1010;
    localparam int         PRE_LEN          = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // One spare bit over the longest phase so terminal compares never wrap.
    function automatic int cnt_width(input int data_w, input int gap_cycles);
        return $clog2(max3(PRE_LEN, data_w, gap_cycles)) + 1;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, MSB-first shift register; dout is the registered bit on the
// line, the remaining bits queue behind it and zeros fill from the bottom.
module piso_shreg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] shreg_r;
    logic             bit_r;

    // Load puts the MSB straight on the line; idle cycles clear to keep the line at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= {WIDTH{1'b0}};
            bit_r   <= 1'b0;
        end else if (load) begin
            bit_r   <= din[WIDTH-1];
            shreg_r <= {din[WIDTH-2:0], 1'b0};
        end else if (shift) begin
            bit_r   <= shreg_r[WIDTH-1];
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
        end else begin
            shreg_r <= {WIDTH{1'b0}};
            bit_r   <= 1'b0;
        end
    end

    assign dout = bit_r;

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: preamble then payload, MSB first, followed by an
// idle gap; abortable mid-frame, all outputs derived from registers.
module seq_tx
    import seq_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter logic [3:0] PREAMBLE   = PREAMBLE_DEFAULT,
    parameter int         GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic              abort,
    output logic              ready,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_W = PRE_LEN + DATA_W;
    localparam int CNT_W   = cnt_width(DATA_W, GAP_CYCLES);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam state_t           DATA_EXIT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               load_s;
    logic               shift_s;
    logic               sdo_valid_nxt_s;
    logic               done_nxt_s;
    logic               sdo_valid_r;
    logic               done_r;
    logic               sdo_s;
    logic [FRAME_W-1:0] frame_s;

    assign frame_s = {PREAMBLE, data};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Per-phase bit counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (next_state_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic; abort only matters while a frame is on the line.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    next_state_s = ST_PRE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == PRE_LAST) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_PRE;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == DATA_LAST) begin
                    next_state_s = DATA_EXIT;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Shifter control and next values of the registered outputs.
    always_comb begin
        load_s          = 1'b0;
        shift_s         = 1'b0;
        sdo_valid_nxt_s = 1'b0;
        done_nxt_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s          = valid;
                sdo_valid_nxt_s = valid;
            end
            ST_PRE: begin
                if (abort) begin
                    shift_s         = 1'b0;
                    sdo_valid_nxt_s = 1'b0;
                end else begin
                    shift_s         = 1'b1;
                    sdo_valid_nxt_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    shift_s         = 1'b0;
                    sdo_valid_nxt_s = 1'b0;
                end else if (cnt_r == DATA_LAST) begin
                    done_nxt_s      = 1'b1;
                end else begin
                    shift_s         = 1'b1;
                    sdo_valid_nxt_s = 1'b1;
                end
            end
            ST_GAP: begin
                load_s          = 1'b0;
                sdo_valid_nxt_s = 1'b0;
            end
            default: begin
                load_s          = 1'b0;
                shift_s         = 1'b0;
            end
        endcase
    end

    // Registered qualifier and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdo_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            sdo_valid_r <= sdo_valid_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    piso_shreg #(
        .WIDTH (FRAME_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .din   (frame_s),
        .dout  (sdo_s)
    );

    assign ready     = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign sdo       = sdo_s;
    assign sdo_valid = sdo_valid_r;
    assign done      = done_r;

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: scoreboard of expected serial bits, a 1010
// overlapping detector on the line, and a DATA_W=1 / GAP_CYCLES=0 instance.
module tb_seq_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid, abort;
    logic [7:0] data;
    logic       ready, sdo, sdo_valid, busy, done;
    logic       valid2, abort2;
    logic [0:0] data2;
    logic       ready2, sdo2, sdo_valid2, busy2, done2;

    seq_tx #(.DATA_W(8), .PREAMBLE(4'b1010), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data(data), .abort(abort),
        .ready(ready), .sdo(sdo), .sdo_valid(sdo_valid), .busy(busy), .done(done)
    );

    seq_tx #(.DATA_W(1), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .valid(valid2), .data(data2), .abort(abort2),
        .ready(ready2), .sdo(sdo2), .sdo_valid(sdo_valid2), .busy(busy2), .done(done2)
    );

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    logic exp2_q[$];
    int   done_cnt = 0;
    int   done2_cnt = 0;
    int   bit_idx = 0;
    int   y_pos[$];
    logic [1:0] det_st = 2'd0;
    int   gap, idle_seen, dc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [11:0] f);
        for (int i = 11; i >= 0; i--) exp_q.push_back(f[i]);
    endtask

    task automatic push2(input logic [4:0] f);
        for (int i = 4; i >= 0; i--) exp2_q.push_back(f[i]);
    endtask

    // One clock: sample after the edge, pop the scoreboards, run the detector.
    task automatic tick();
        logic y;
        @(posedge clk);
        #1;
        if (done)  done_cnt++;
        if (done2) done2_cnt++;
        if (sdo_valid) begin
            bit_idx++;
            y = (det_st == 2'd3) && (sdo == 1'b0);
            case (det_st)
                2'd0:    det_st = sdo ? 2'd1 : 2'd0;
                2'd1:    det_st = sdo ? 2'd1 : 2'd2;
                2'd2:    det_st = sdo ? 2'd3 : 2'd0;
                2'd3:    det_st = sdo ? 2'd1 : 2'd2;
                default: det_st = 2'd0;
            endcase
            if (y) y_pos.push_back(bit_idx);
            if (exp_q.size() == 0) check("sdo_extra", sdo_valid, 1'b0);
            else check("sdo_bit", sdo, exp_q.pop_front());
        end
        if (sdo_valid2) begin
            if (exp2_q.size() == 0) check("sdo2_extra", sdo_valid2, 1'b0);
            else check("sdo2_bit", sdo2, exp2_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; abort = 1'b0; data = 8'h00;
        valid2 = 1'b0; abort2 = 1'b0; data2 = 1'b0;
        #12;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_sdo", sdo, 1'b0);
        check("rst_sdo_valid", sdo_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready2", ready2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_ready", ready, 1'b1);

        // Single frame A5.
        data = 8'hA5; valid = 1'b1; push_frame({4'b1010, 8'hA5});
        tick();
        valid = 1'b0; data = 8'h00;
        check("a5_busy", busy, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            check("a5_sdo_valid", sdo_valid, 1'b1);
            if (i < 12) tick();
        end
        tick();
        check("a5_done13", done, 1'b1);
        check("a5_sdo_valid13", sdo_valid, 1'b0);
        check("a5_sdo13", sdo, 1'b0);
        check("a5_ready13", ready, 1'b0);
        tick();
        check("a5_done14", done, 1'b0);
        check("a5_busy14", busy, 1'b1);
        tick();
        check("a5_ready15", ready, 1'b1);
        check("a5_busy15", busy, 1'b0);
        check("a5_sb_empty", exp_q.size(), 0);
        check("a5_done_cnt", done_cnt, 1);

        // Back-to-back FF then 00 with valid held high.
        data = 8'hFF; valid = 1'b1; push_frame({4'b1010, 8'hFF});
        tick();
        data = 8'h00; push_frame({4'b1010, 8'h00});
        for (int i = 2; i <= 12; i++) tick();
        gap = 0; idle_seen = 0;
        tick();
        while (!sdo_valid && gap < 20) begin
            gap++;
            if (ready) idle_seen++;
            tick();
        end
        valid = 1'b0;
        check("b2b_gap", gap, 3);
        check("b2b_idle", idle_seen, 1);
        for (int i = 2; i <= 12; i++) tick();
        tick();
        check("b2b_done", done, 1'b1);
        tick();
        tick();
        check("b2b_ready", ready, 1'b1);
        check("b2b_sb_empty", exp_q.size(), 0);
        check("b2b_done_cnt", done_cnt, 3);

        // Abort during data bit 3 of 3C, then accept 0A with abort still high.
        data = 8'h3C; valid = 1'b1; push_frame({4'b1010, 8'h3C});
        tick();
        valid = 1'b0;
        for (int i = 2; i <= 8; i++) tick();
        abort = 1'b1; dc = done_cnt;
        tick();
        check("abort_sdo_valid", sdo_valid, 1'b0);
        check("abort_sdo", sdo, 1'b0);
        check("abort_ready", ready, 1'b1);
        exp_q.delete();
        valid = 1'b1; data = 8'h0A;
        det_st = 2'd0; bit_idx = 0; y_pos.delete();
        push_frame({4'b1010, 8'h0A});
        tick();
        check("abort_idle_accept", sdo_valid, 1'b1);
        check("abort_idle_busy", ready, 1'b0);
        check("abort_no_done", done_cnt, dc);
        abort = 1'b0; valid = 1'b0;
        for (int i = 2; i <= 12; i++) tick();
        tick();
        check("loop_done", done, 1'b1);
        abort = 1'b1;
        tick();
        check("gap_abort_busy", busy, 1'b1);
        check("gap_abort_sdo_valid", sdo_valid, 1'b0);
        abort = 1'b0;
        tick();
        check("gap_abort_ready", ready, 1'b1);
        check("loop_y_count", y_pos.size(), 2);
        if (y_pos.size() >= 2) begin
            check("loop_y_first", y_pos[0], 4);
            check("loop_y_second", y_pos[1], 12);
        end
        check("loop_done_cnt", done_cnt, dc + 1);

        // Reset pulled during data bit 3.
        data = 8'hA5; valid = 1'b1; push_frame({4'b1010, 8'hA5});
        tick();
        valid = 1'b0;
        for (int i = 2; i <= 8; i++) tick();
        dc = done_cnt;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_sdo", sdo, 1'b0);
        check("mid_rst_sdo_valid", sdo_valid, 1'b0);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        data = 8'h5A; valid = 1'b1; push_frame({4'b1010, 8'h5A});
        tick();
        check("rst_first_accept", sdo_valid, 1'b1);
        check("rst_first_busy", busy, 1'b1);
        valid = 1'b0;
        for (int i = 2; i <= 12; i++) tick();
        tick();
        check("rst_frame_done", done, 1'b1);
        tick();
        tick();
        check("rst_frame_ready", ready, 1'b1);
        check("rst_done_cnt", done_cnt, dc + 1);
        check("rst_sb_empty", exp_q.size(), 0);

        // DATA_W=1, GAP_CYCLES=0 instance, valid held high.
        data2 = 1'b1; valid2 = 1'b1; push2(5'b10101);
        tick();
        for (int i = 1; i <= 5; i++) begin
            check("w1_sdo_valid", sdo_valid2, 1'b1);
            if (i < 5) tick();
        end
        tick();
        check("w1_done_idle", done2, 1'b1);
        check("w1_ready_idle", ready2, 1'b1);
        check("w1_sdo_valid_idle", sdo_valid2, 1'b0);
        check("w1_sdo_idle", sdo2, 1'b0);
        data2 = 1'b0; push2(5'b10100);
        tick();
        check("w1_period6", sdo_valid2, 1'b1);
        check("w1_done_clear", done2, 1'b0);
        valid2 = 1'b0;
        for (int i = 2; i <= 5; i++) tick();
        tick();
        check("w1_done2", done2, 1'b1);
        check("w1_ready2", ready2, 1'b1);
        tick();
        check("w1_done_pulse", done2, 1'b0);
        check("w1_sb_empty", exp2_q.size(), 0);
        check("w1_done_cnt", done2_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
